// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_RECOVER
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  // Default number of baud_tick strobes per bit period.
  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level; resets to 1 (idle line).
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  // Two register stages; the first may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with optional parity, a one-word output
// holding register and framing/parity/overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int      DATA_BITS  = 8,
  parameter int      OVERSAMPLE = UART_OVERSAMPLE,
  parameter parity_t PARITY     = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Mid-start-bit check point, end-of-bit sample point, last data bit index.
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_tick_end;
  logic                 w_par_mis;
  logic                 w_accept;

  rx_state_t            r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_mis;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_ferr;
  logic                 r_perr;
  logic                 r_oerr;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rx_s)
  );

  assign w_tick_end = (r_tick_cnt == TICK_END);
  // Data XOR parity bit must be 0 for even parity, 1 for odd parity.
  assign w_par_mis  = ((^r_shift) ^ w_rx_s) != (PARITY == PAR_ODD);
  assign w_accept   = r_data_valid & data_ready;

  // Receive FSM, output holding register and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_mis    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_ferr       <= 1'b0;
      r_perr       <= 1'b0;
      r_oerr       <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
      r_oerr <= 1'b0;
      // A later load of a new word in this same cycle overrides this clear.
      if (w_accept) r_data_valid <= 1'b0;
      if (baud_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_rx_s) begin
              r_state    <= ST_START;
              r_tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (r_tick_cnt == TICK_MID) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_par_mis  <= 1'b0;
              r_state    <= w_rx_s ? ST_IDLE : ST_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (w_tick_end) begin
              r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              r_tick_cnt <= '0;
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == BIT_LAST)
                r_state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PAR;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          ST_PAR: begin
            if (w_tick_end) begin
              r_par_mis  <= w_par_mis;
              r_tick_cnt <= '0;
              r_state    <= ST_STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (w_tick_end) begin
              r_tick_cnt <= '0;
              if (!w_rx_s) begin
                r_ferr  <= 1'b1;
                r_state <= ST_RECOVER;
              end else if (r_par_mis) begin
                r_perr  <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_IDLE;
                if (!r_data_valid || data_ready) begin
                  r_data_out   <= r_shift;
                  r_data_valid <= 1'b1;
                end else begin
                  r_oerr <= 1'b1;
                end
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          ST_RECOVER: begin
            // Hold here through a line break until the line idles high.
            if (w_rx_s) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign framing_err = r_ferr;
  assign parity_err  = r_perr;
  assign overrun_err = r_oerr;
  assign busy        = (r_state != ST_IDLE);

endmodule
